decode: RTL and testbench
=========================

# decode

Second pipeline stage of the MIPS core. Consumes the fetched instruction word from instruction memory and the PC issued by `fetch`, then decodes the opcode, funct and immediate fields. Reads operands from an internal 32×32 register file and detects load-use hazards, asserting `stall` back to `fetch`. Results are registered into the ID/EX pipeline register that feeds `execute`.

## Interface
- `STACK_INIT`, 32'h80120000: value loaded into r29 at reset; all other registers reset to 0.
- `clock` in 1: single system clock; all state updates on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `pc_in` in 32: PC from `fetch`; 32'h0 marks a bubble.
- `insn_in` in 32: instruction word from instruction memory for `pc_in`.
- `do_branch` in 1: branch/jump taken in `execute`; flushes this stage.
- `wb_en` in 1: register-file write enable from writeback.
- `wb_addr` in 5: writeback destination.
- `wb_data` in 32: writeback value.
- `stall` out 1: combinational load-use hazard indication to `fetch`.
- `pc_out` out 32: registered PC of the decoded instruction; 0 for a bubble.
- `insn_out` out 32: registered instruction word; 0 for a bubble.
- `rs_data`, `rt_data` out 32 each: registered operand values.
- `imm_ext` out 32: registered immediate, extended per opcode.
- `dest` out 5: registered destination register.
- `alu_op` out 4: registered ALU operation code, from the package.
- `alu_src`, `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `is_branch`, `is_jump` out 1 each: registered control signals.
- `mem_size` out 2: registered memory access width; 00 = word, 10 = byte.
- `illegal` out 1: registered flag for an unsupported opcode/funct.

## Operation
- **Register file:** write on posedge when `wb_en` is high and `wb_addr` ≠ 0. r0 always reads 0. Reads bypass writes: if the same cycle writes `wb_addr` equal to rs or rt, the registered operand takes `wb_data`.
- **Supported R-type instructions:** add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
- **Supported I-type instructions:** addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, lb, lbu, sb, beq, bne, blez, bgtz.
- **Supported J-type instructions:** j, jal.
- **Immediate extension:** andi, ori and xori zero-extend; lui places imm in [31:16] with zeros below; all other I-types sign-extend. For j and jal, `imm_ext` = {pc_in[31:28], target, 2'b00}.
- **Destination:** R-type uses rd; I-type loads and ALU ops use rt; jal uses 31. `reg_write` = 0 for stores, branches, j and jr.
- **Unsupported encoding:** produces a bubble with `illegal` = 1, held for one cycle.
- **Bubble:** all registered outputs 0, `alu_op` = ALU_NOP.
- **Hazard:** `stall` = ID/EX `mem_read` & (`dest` ≠ 0) & (`dest` == rs, where rs is used, or `dest` == rt, where rt is a source) & !`do_branch`.
  - rt counts as a source for R-type, stores, beq and bne only.
- **Bubble insertion:** on posedge, insert a bubble if `do_branch`, `stall`, or `pc_in` == 0. Otherwise latch the decoded instruction.
- Under `stall`, `fetch` re-presents the same instruction next cycle, so this stage holds no instruction buffer.

## Timing
- Latency: one cycle from `pc_in`/`insn_in` to the registered outputs.
- Throughput: one instruction per cycle absent hazards.
- **Reset:** with `resetn` low at posedge, all outputs become a bubble, r1–r31 are cleared, and r29 = `STACK_INIT`. `stall` = 0 the cycle after reset.
- A reset in the middle of a stall discards the pending instruction.
- **`do_branch` and `stall` in the same cycle:** `stall` is forced to 0 and the ID/EX register receives a bubble.
- **Writeback and decode of the same register in the same cycle:** the bypassed value is used.
- A writeback to r0 has no effect.
- A load-use hazard costs exactly one bubble. The next cycle's ID/EX holds a bubble, so `stall` drops.

## Structure
- Shared package `mips_defs`: opcode and funct constants, the ALU_* encodings (including ALU_NOP = 4'h0), and the `mem_size` codes. Shared with `execute`.
- Sub-module `regfile`: two combinational read ports, one write port, write bypass, and synchronous reset carrying the `STACK_INIT` parameter.
- The decode logic and the ID/EX register stay in `decode`.

## Test plan
- **Reset:** hold `resetn` low for 2 cycles. Expect all outputs 0 and `stall` 0; an `addu` of r29 + r0 then reads `rs_data` = 32'h80120000.
- **Immediate extension:** `addiu r8,r0,-1` (32'h2408FFFF) at pc 80020000 → next cycle `imm_ext` = FFFFFFFF, `dest` = 8, `alu_src` = 1, `reg_write` = 1. `ori` with imm 8000 → `imm_ext` = 00008000.
- **Load-use:** `lw r9,0(r8)` followed by `addu r10,r9,r9` → `stall` = 1 for one cycle and one bubble enters ID/EX. The `addu` issues the next cycle. `addu r10,r8,r8` after the `lw` → no stall.
- **Write bypass:** `wb_en` = 1, `wb_addr` = 5, `wb_data` = DEADBEEF in the same cycle that `or r6,r5,r0` is decoded → `rs_data` = DEADBEEF. A write to r0 followed by a read → 0.
- **Flush with stall:** `do_branch` = 1 while a load-use stall condition holds → `stall` = 0 and ID/EX becomes a bubble. `pc_in` = 0 → bubble.
- **jal and illegal:** `jal` at pc 80020010 with target 0x0008004 → `dest` = 31, `imm_ext` = 80020010 & F0000000 | 00020010 = 80020010, `is_jump` = 1. Opcode 6'h3F → `illegal` = 1 for one cycle, all control signals 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, functs, ALU and memory-size encodings, ID/EX layout.
package mips_defs;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes consumed by execute
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_ADDU = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_SUBU = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_XOR  = 4'h7;
    localparam logic [3:0] ALU_NOR  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;
    localparam logic [3:0] ALU_SLL  = 4'hB;
    localparam logic [3:0] ALU_SRL  = 4'hC;
    localparam logic [3:0] ALU_SRA  = 4'hD;
    localparam logic [3:0] ALU_LUI  = 4'hE;

    // Memory access widths
    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    typedef enum logic [1:0] {ExtSign, ExtZero, ExtLui, ExtJump} ext_e;
    typedef enum logic [1:0] {DstNone, DstRd, DstRt, DstRa} dst_e;

    // ID/EX pipeline register; all-zero is a bubble (alu_op == ALU_NOP)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  dest;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        is_branch;
        logic        is_jump;
        logic [1:0]  mem_size;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write bypass, one write port.
module regfile #(
    parameter logic [31:0] STACK_INIT = 32'h8012_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    // Write port with synchronous reset; r29 starts as the stack pointer
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? STACK_INIT : 32'd0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: same-cycle write is forwarded, r0 always reads zero
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
        if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
        if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
        if (raddr_a_i == 5'd0) rdata_a_o = 32'd0;
        if (raddr_b_i == 5'd0) rdata_b_o = 32'd0;
    end

endmodule

// File: rtl/decode.sv
// Decode stage: field decode, operand read, load-use hazard detection, ID/EX register.
module decode
    import mips_defs::*;
#(
    parameter logic [31:0] STACK_INIT = 32'h8012_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] pc_in,
    input  logic [31:0] insn_in,
    input  logic        do_branch,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  dest,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        is_branch,
    output logic        is_jump,
    output logic [1:0]  mem_size,
    output logic        illegal
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic        legal, rs_used, rt_src, bubble;
    ext_e        ext;
    dst_e        dst;
    id_ex_t      dec, id_ex_d, id_ex_q;

    assign op    = insn_in[31:26];
    assign rs    = insn_in[25:21];
    assign rt    = insn_in[20:16];
    assign rd    = insn_in[15:11];
    assign funct = insn_in[5:0];

    regfile #(.STACK_INIT(STACK_INIT)) u_regfile (
        .clock     (clock),
        .resetn    (resetn),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    // Decode opcode/funct into control signals and operand-usage flags
    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        rs_used = 1'b1;
        rt_src  = 1'b0;
        ext     = ExtSign;
        dst     = DstNone;
        case (op)
            OP_RTYPE: begin
                rt_src        = 1'b1;
                dst           = DstRd;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_ADDU: dec.alu_op = ALU_ADDU;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_SUBU: dec.alu_op = ALU_SUBU;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLTU: dec.alu_op = ALU_SLTU;
                    FN_SLL:  begin dec.alu_op = ALU_SLL; rs_used = 1'b0; end
                    FN_SRL:  begin dec.alu_op = ALU_SRL; rs_used = 1'b0; end
                    FN_SRA:  begin dec.alu_op = ALU_SRA; rs_used = 1'b0; end
                    FN_JR: begin
                        dec.is_jump   = 1'b1;
                        dec.reg_write = 1'b0;
                        dst           = DstNone;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_J: begin
                dec.is_jump = 1'b1;
                rs_used     = 1'b0;
                ext         = ExtJump;
            end
            OP_JAL: begin
                dec.is_jump   = 1'b1;
                dec.reg_write = 1'b1;
                rs_used       = 1'b0;
                ext           = ExtJump;
                dst           = DstRa;
            end
            OP_BEQ, OP_BNE: begin
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
                rt_src        = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dst           = DstRt;
                case (op)
                    OP_ADDI:  dec.alu_op = ALU_ADD;
                    OP_ADDIU: dec.alu_op = ALU_ADDU;
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI:  begin dec.alu_op = ALU_AND; ext = ExtZero; end
                    OP_ORI:   begin dec.alu_op = ALU_OR;  ext = ExtZero; end
                    OP_XORI:  begin dec.alu_op = ALU_XOR; ext = ExtZero; end
                    OP_LUI:   begin dec.alu_op = ALU_LUI; ext = ExtLui; rs_used = 1'b0; end
                    default:  dec.alu_op = ALU_NOP;
                endcase
            end
            OP_LW, OP_LB, OP_LBU: begin
                dec.alu_op     = ALU_ADDU;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_size   = (op == OP_LW) ? MEM_WORD : MEM_BYTE;
                dst            = DstRt;
            end
            OP_SW, OP_SB: begin
                dec.alu_op    = ALU_ADDU;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_size  = (op == OP_SW) ? MEM_WORD : MEM_BYTE;
                rt_src        = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // An unsupported encoding becomes a bubble, so it must never raise a hazard
        if (!legal) begin
            rs_used = 1'b0;
            rt_src  = 1'b0;
        end

        dec.pc      = pc_in;
        dec.insn    = insn_in;
        dec.rs_data = rs_val;
        dec.rt_data = rt_val;

        case (ext)
            ExtSign: dec.imm_ext = {{16{insn_in[15]}}, insn_in[15:0]};
            ExtZero: dec.imm_ext = {16'd0, insn_in[15:0]};
            ExtLui:  dec.imm_ext = {insn_in[15:0], 16'd0};
            ExtJump: dec.imm_ext = {pc_in[31:28], insn_in[25:0], 2'b00};
        endcase

        case (dst)
            DstNone: dec.dest = 5'd0;
            DstRd:   dec.dest = rd;
            DstRt:   dec.dest = rt;
            DstRa:   dec.dest = 5'd31;
        endcase
    end

    // Load-use hazard against the load currently in ID/EX; a taken branch overrides it
    assign stall = id_ex_q.mem_read && (id_ex_q.dest != 5'd0) &&
                   ((rs_used && (id_ex_q.dest == rs)) || (rt_src && (id_ex_q.dest == rt))) &&
                   !do_branch;

    assign bubble = do_branch || stall || (pc_in == 32'd0) || !legal;

    // Next ID/EX contents: decoded instruction or bubble, flagging real illegal encodings
    always_comb begin
        id_ex_d = dec;
        if (bubble) begin
            id_ex_d         = '0;
            id_ex_d.illegal = !legal && !do_branch && (pc_in != 32'd0);
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign pc_out     = id_ex_q.pc;
    assign insn_out   = id_ex_q.insn;
    assign rs_data    = id_ex_q.rs_data;
    assign rt_data    = id_ex_q.rt_data;
    assign imm_ext    = id_ex_q.imm_ext;
    assign dest       = id_ex_q.dest;
    assign alu_op     = id_ex_q.alu_op;
    assign alu_src    = id_ex_q.alu_src;
    assign reg_write  = id_ex_q.reg_write;
    assign mem_read   = id_ex_q.mem_read;
    assign mem_write  = id_ex_q.mem_write;
    assign mem_to_reg = id_ex_q.mem_to_reg;
    assign is_branch  = id_ex_q.is_branch;
    assign is_jump    = id_ex_q.is_jump;
    assign mem_size   = id_ex_q.mem_size;
    assign illegal    = id_ex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized traffic vs an ISA-table model.
module tb_decode;
    import mips_defs::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pc_in = '0, insn_in = '0, wb_data = '0;
    logic        do_branch = 1'b0, wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        stall, alu_src, reg_write, mem_read, mem_write, mem_to_reg;
    logic        is_branch, is_jump, illegal;
    logic [31:0] pc_out, insn_out, rs_data, rt_data, imm_ext;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic [1:0]  mem_size;

    always #5 clock = ~clock;

    decode dut (
        .clock(clock), .resetn(resetn), .pc_in(pc_in), .insn_in(insn_in),
        .do_branch(do_branch), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .pc_out(pc_out), .insn_out(insn_out), .rs_data(rs_data),
        .rt_data(rt_data), .imm_ext(imm_ext), .dest(dest), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .is_branch(is_branch),
        .is_jump(is_jump), .mem_size(mem_size), .illegal(illegal)
    );

    id_ex_t obs;
    assign obs = {pc_out, insn_out, rs_data, rt_data, imm_ext, dest, alu_op, alu_src, reg_write,
                  mem_read, mem_write, mem_to_reg, is_branch, is_jump, mem_size, illegal};

    // ISA description table: flags s=alu_src w=reg_write l=load m=store b=branch j=jump
    // B=byte access r=rs read t=rt is a source; ext S/Z/U/J; dest d=rd t=rt a=r31 -=none
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        bit alu_src, reg_write, load, store, branch, jump, byte_sz, rs_used, rt_src;
        byte ext;
        byte dst;
    } isa_t;

    isa_t        isa[$];
    logic [31:0] m_regs[32];
    id_ex_t      m_q = '0;
    logic        got_stall, exp_stall;
    int          n_checks = 0, n_pass = 0;

    function automatic bit has(string s, byte c);
        for (int i = 0; i < s.len(); i++) if (s.getc(i) == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void add_isa(logic [5:0] op, logic [5:0] fn, logic [3:0] alu, string fl,
                                    byte ext, byte dst);
        isa_t e;
        e.op = op; e.fn = fn; e.alu = alu; e.ext = ext; e.dst = dst;
        e.alu_src = has(fl, "s"); e.reg_write = has(fl, "w"); e.load = has(fl, "l");
        e.store = has(fl, "m"); e.branch = has(fl, "b"); e.jump = has(fl, "j");
        e.byte_sz = has(fl, "B"); e.rs_used = has(fl, "r"); e.rt_src = has(fl, "t");
        isa.push_back(e);
    endfunction

    function automatic void init_isa();
        add_isa(6'h00, 6'h20, ALU_ADD,  "wrt", "S", "d");
        add_isa(6'h00, 6'h21, ALU_ADDU, "wrt", "S", "d");
        add_isa(6'h00, 6'h22, ALU_SUB,  "wrt", "S", "d");
        add_isa(6'h00, 6'h23, ALU_SUBU, "wrt", "S", "d");
        add_isa(6'h00, 6'h24, ALU_AND,  "wrt", "S", "d");
        add_isa(6'h00, 6'h25, ALU_OR,   "wrt", "S", "d");
        add_isa(6'h00, 6'h26, ALU_XOR,  "wrt", "S", "d");
        add_isa(6'h00, 6'h27, ALU_NOR,  "wrt", "S", "d");
        add_isa(6'h00, 6'h2A, ALU_SLT,  "wrt", "S", "d");
        add_isa(6'h00, 6'h2B, ALU_SLTU, "wrt", "S", "d");
        add_isa(6'h00, 6'h00, ALU_SLL,  "wt",  "S", "d");
        add_isa(6'h00, 6'h02, ALU_SRL,  "wt",  "S", "d");
        add_isa(6'h00, 6'h03, ALU_SRA,  "wt",  "S", "d");
        add_isa(6'h00, 6'h08, ALU_NOP,  "jrt", "S", "-");
        add_isa(6'h08, 6'h00, ALU_ADD,  "swr", "S", "t");
        add_isa(6'h09, 6'h00, ALU_ADDU, "swr", "S", "t");
        add_isa(6'h0A, 6'h00, ALU_SLT,  "swr", "S", "t");
        add_isa(6'h0B, 6'h00, ALU_SLTU, "swr", "S", "t");
        add_isa(6'h0C, 6'h00, ALU_AND,  "swr", "Z", "t");
        add_isa(6'h0D, 6'h00, ALU_OR,   "swr", "Z", "t");
        add_isa(6'h0E, 6'h00, ALU_XOR,  "swr", "Z", "t");
        add_isa(6'h0F, 6'h00, ALU_LUI,  "sw",  "U", "t");
        add_isa(6'h23, 6'h00, ALU_ADDU, "swlr",  "S", "t");
        add_isa(6'h20, 6'h00, ALU_ADDU, "swlrB", "S", "t");
        add_isa(6'h24, 6'h00, ALU_ADDU, "swlrB", "S", "t");
        add_isa(6'h2B, 6'h00, ALU_ADDU, "smrt",  "S", "-");
        add_isa(6'h28, 6'h00, ALU_ADDU, "smrtB", "S", "-");
        add_isa(6'h04, 6'h00, ALU_SUB,  "brt", "S", "-");
        add_isa(6'h05, 6'h00, ALU_SUB,  "brt", "S", "-");
        add_isa(6'h06, 6'h00, ALU_SUB,  "br",  "S", "-");
        add_isa(6'h07, 6'h00, ALU_SUB,  "br",  "S", "-");
        add_isa(6'h02, 6'h00, ALU_NOP,  "j",   "J", "-");
        add_isa(6'h03, 6'h00, ALU_NOP,  "jw",  "J", "a");
    endfunction

    function automatic int find_isa(logic [31:0] w);
        foreach (isa[k]) begin
            if (isa[k].op == w[31:26] && (w[31:26] != 6'h00 || isa[k].fn == w[5:0])) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a, logic we, logic [4:0] wa,
                                           logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic model_stall(logic [31:0] w, logic br);
        int k = find_isa(w);
        if (k < 0 || br || !m_q.mem_read || m_q.dest == 5'd0) return 1'b0;
        return (isa[k].rs_used && m_q.dest == w[25:21]) || (isa[k].rt_src && m_q.dest == w[20:16]);
    endfunction

    function automatic id_ex_t model_next(logic [31:0] pc, logic [31:0] w, logic br, logic st,
                                          logic we, logic [4:0] wa, logic [31:0] wd);
        id_ex_t e;
        int k;
        e = '0;
        k = find_isa(w);
        if (br || st || pc == 32'd0) return e;
        if (k < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.pc = pc;
        e.insn = w;
        e.rs_data = m_read(w[25:21], we, wa, wd);
        e.rt_data = m_read(w[20:16], we, wa, wd);
        case (isa[k].ext)
            "Z":     e.imm_ext = {16'h0, w[15:0]};
            "U":     e.imm_ext = {w[15:0], 16'h0};
            "J":     e.imm_ext = {pc[31:28], w[25:0], 2'b00};
            default: e.imm_ext = {{16{w[15]}}, w[15:0]};
        endcase
        case (isa[k].dst)
            "d":     e.dest = w[15:11];
            "t":     e.dest = w[20:16];
            "a":     e.dest = 5'd31;
            default: e.dest = 5'd0;
        endcase
        e.alu_op = isa[k].alu;
        e.alu_src = isa[k].alu_src;
        e.reg_write = isa[k].reg_write;
        e.mem_read = isa[k].load;
        e.mem_to_reg = isa[k].load;
        e.mem_write = isa[k].store;
        e.is_branch = isa[k].branch;
        e.is_jump = isa[k].jump;
        e.mem_size = (isa[k].byte_sz) ? 2'b10 : 2'b00;
        return e;
    endfunction

    // One clock: drive inputs, sample stall mid-cycle, advance model past the edge
    task automatic cycle(input logic [31:0] pc, input logic [31:0] w, input logic br,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        id_ex_t nxt;
        pc_in = pc; insn_in = w; do_branch = br; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        got_stall = stall;
        exp_stall = model_stall(w, br);
        nxt = model_next(pc, w, br, exp_stall, we, wa, wd);
        @(posedge clock);
        #1;
        if (!resetn) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_regs[29] = 32'h8012_0000;
            m_q = '0;
        end else begin
            m_q = nxt;
            if (we && wa != 5'd0) m_regs[wa] = wd;
        end
    endtask

    function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        cycle(32'h8002_0000, i_ins(6'h23, 5'd8, 5'd9, 16'h0), 1'b0, 1'b1, 5'd3, 32'h1234);
        cycle(32'h8002_0004, r_ins(5'd9, 5'd9, 5'd10, 6'h21), 1'b0, 1'b1, 5'd3, 32'h1234);
        n_checks++;
        if (obs !== '0) $display("FAIL reset_bubble: got %h expected 0", obs); else n_pass++;
        resetn = 1'b1;
        cycle(32'h8002_0000, r_ins(5'd29, 5'd0, 5'd1, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", got_stall);
        else n_pass++;
        n_checks++;
        if (rs_data !== 32'h8012_0000) $display("FAIL reset_sp: got %h expected 80120000", rs_data);
        else n_pass++;
        n_checks++;
        if (obs !== m_q) $display("FAIL reset_addu: got %h expected %h", obs, m_q); else n_pass++;
        cycle(32'h8002_0004, r_ins(5'd3, 5'd0, 5'd1, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (rs_data !== 32'h0) $display("FAIL reset_r3: got %h expected 0", rs_data); else n_pass++;
    endtask

    task automatic test_imm_ext();
        cycle(32'h8002_0000, 32'h2408_FFFF, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if ({imm_ext, dest, alu_src, reg_write} !== {32'hFFFF_FFFF, 5'd8, 1'b1, 1'b1})
            $display("FAIL addiu_fields: got %h/%0d/%b/%b expected ffffffff/8/1/1",
                     imm_ext, dest, alu_src, reg_write);
        else n_pass++;
        n_checks++;
        if (obs !== m_q) $display("FAIL addiu_all: got %h expected %h", obs, m_q); else n_pass++;
        cycle(32'h8002_0004, i_ins(6'h0D, 5'd0, 5'd9, 16'h8000), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (imm_ext !== 32'h0000_8000) $display("FAIL ori_imm: got %h expected 00008000", imm_ext);
        else n_pass++;
        cycle(32'h8002_0008, i_ins(6'h0F, 5'd0, 5'd11, 16'h1234), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (imm_ext !== 32'h1234_0000) $display("FAIL lui_imm: got %h expected 12340000", imm_ext);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [31:0] lw9, use9, sw9;
        lw9 = i_ins(6'h23, 5'd8, 5'd9, 16'h0);
        use9 = r_ins(5'd9, 5'd9, 5'd10, 6'h21);
        sw9 = i_ins(6'h2B, 5'd8, 5'd9, 16'h0);
        cycle(32'h0, 32'h0, 1'b0, 1'b1, 5'd8, 32'h100);
        cycle(32'h8002_0010, lw9, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (obs !== m_q || rs_data !== 32'h100 || mem_read !== 1'b1)
            $display("FAIL lw_issue: got %h expected %h", obs, m_q);
        else n_pass++;
        cycle(32'h8002_0014, use9, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b1) $display("FAIL lu_stall: got %b expected 1", got_stall);
        else n_pass++;
        n_checks++;
        if (obs !== '0) $display("FAIL lu_bubble: got %h expected 0", obs); else n_pass++;
        cycle(32'h8002_0014, use9, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b0 || insn_out !== use9)
            $display("FAIL lu_reissue: got stall %b insn %h expected 0 %h", got_stall, insn_out, use9);
        else n_pass++;
        cycle(32'h8002_0018, lw9, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(32'h8002_001C, r_ins(5'd8, 5'd8, 5'd10, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b0 || pc_out !== 32'h8002_001C)
            $display("FAIL lu_indep: got stall %b pc %h expected 0 8002001c", got_stall, pc_out);
        else n_pass++;
        cycle(32'h8002_0020, lw9, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(32'h8002_0024, sw9, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b1) $display("FAIL lu_store_rt: got %b expected 1", got_stall);
        else n_pass++;
        // Reset while the dependent instruction is stalled discards it
        cycle(32'h8002_0024, lw9, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(32'h8002_0028, use9, 1'b0, 1'b0, 5'd0, 32'h0);
        resetn = 1'b0;
        cycle(32'h8002_0028, use9, 1'b0, 1'b0, 5'd0, 32'h0);
        resetn = 1'b1;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_in_stall: got %h expected 0", obs); else n_pass++;
        cycle(32'h8002_0028, use9, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b0 || pc_out !== 32'h8002_0028)
            $display("FAIL post_reset_issue: got stall %b pc %h expected 0 80020028",
                     got_stall, pc_out);
        else n_pass++;
    endtask

    task automatic test_bypass();
        cycle(32'h8002_0030, r_ins(5'd5, 5'd0, 5'd6, 6'h25), 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        n_checks++;
        if (rs_data !== 32'hDEAD_BEEF) $display("FAIL bypass_rs: got %h expected deadbeef", rs_data);
        else n_pass++;
        cycle(32'h8002_0034, r_ins(5'd5, 5'd5, 5'd7, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if ({rs_data, rt_data} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF})
            $display("FAIL written_r5: got %h %h expected deadbeef", rs_data, rt_data);
        else n_pass++;
        cycle(32'h8002_0038, r_ins(5'd0, 5'd0, 5'd7, 6'h21), 1'b0, 1'b1, 5'd0, 32'h1234_5678);
        n_checks++;
        if ({rs_data, rt_data} !== 64'h0) $display("FAIL r0_same_cycle: got %h %h expected 0",
                                                   rs_data, rt_data);
        else n_pass++;
        cycle(32'h8002_003C, r_ins(5'd0, 5'd0, 5'd7, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (rs_data !== 32'h0) $display("FAIL r0_after_write: got %h expected 0", rs_data);
        else n_pass++;
    endtask

    task automatic test_flush();
        cycle(32'h8002_0040, i_ins(6'h23, 5'd8, 5'd9, 16'h4), 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(32'h8002_0044, r_ins(5'd9, 5'd9, 5'd10, 6'h21), 1'b1, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (got_stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", got_stall);
        else n_pass++;
        n_checks++;
        if (obs !== '0) $display("FAIL flush_bubble: got %h expected 0", obs); else n_pass++;
        cycle(32'h0, r_ins(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (obs !== '0) $display("FAIL pc0_bubble: got %h expected 0", obs); else n_pass++;
    endtask

    task automatic test_jal_illegal();
        id_ex_t ill;
        ill = '0;
        ill.illegal = 1'b1;
        cycle(32'h8002_0010, {6'h03, 26'h000_8004}, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if ({dest, imm_ext, is_jump, reg_write} !== {5'd31, 32'h8002_0010, 1'b1, 1'b1})
            $display("FAIL jal_fields: got %0d/%h/%b/%b expected 31/80020010/1/1",
                     dest, imm_ext, is_jump, reg_write);
        else n_pass++;
        cycle(32'h8002_0014, {6'h3F, 26'h123_4567}, 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (obs !== ill) $display("FAIL illegal_op: got %h expected %h", obs, ill); else n_pass++;
        cycle(32'h8002_0018, r_ins(5'd1, 5'd2, 5'd3, 6'h3F), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (obs !== ill) $display("FAIL illegal_fn: got %h expected %h", obs, ill); else n_pass++;
        cycle(32'h8002_001C, r_ins(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (illegal !== 1'b0 || obs !== m_q)
            $display("FAIL illegal_clear: got %h expected %h", obs, m_q);
        else n_pass++;
        cycle(32'h8002_0020, r_ins(5'd31, 5'd0, 5'd0, 6'h08), 1'b0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if ({is_jump, reg_write} !== 2'b10 || obs !== m_q)
            $display("FAIL jr: got %h expected %h", obs, m_q);
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int k;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        k = int'($urandom_range(0, isa.size() - 1));
        w[31:26] = isa[k].op;
        if (isa[k].op == 6'h00) w[5:0] = isa[k].fn;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'h0 : (($urandom & 32'hFFFF_FFFC) | 32'h4);
            cycle(pc, rand_insn(), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
            n_checks++;
            if (got_stall !== exp_stall)
                $display("FAIL rand_stall[%0d]: got %b expected %b", i, got_stall, exp_stall);
            else n_pass++;
            n_checks++;
            if (obs !== m_q) $display("FAIL rand_idex[%0d]: got %h expected %h", i, obs, m_q);
            else n_pass++;
        end
    endtask

    initial begin
        init_isa();
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        #1;
        test_reset();
        test_imm_ext();
        test_load_use();
        test_bypass();
        test_flush();
        test_jal_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
